// File: rtl/time_set_ctrl_if.sv
// Bundle between time_set_ctrl and its environment: tick, raw keys
// in; mode, enables, field select, inc strobe, run enable, blink out.
interface time_set_ctrl_if;
  logic       tick_1k;
  logic       key_mode;
  logic       key_sel;
  logic       key_inc;
  logic [1:0] mode;
  logic       time_en;
  logic       alarm_en;
  logic       adjust_h;
  logic       adjust_m;
  logic       adjust_s;
  logic       inc_pulse;
  logic       run_en;
  logic       blink;

  modport master (
    output tick_1k, key_mode, key_sel, key_inc,
    input  mode, time_en, alarm_en,
    input  adjust_h, adjust_m, adjust_s,
    input  inc_pulse, run_en, blink
  );

  modport slave (
    input  tick_1k, key_mode, key_sel, key_inc,
    output mode, time_en, alarm_en,
    output adjust_h, adjust_m, adjust_s,
    output inc_pulse, run_en, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Clock time-set controller: key sync/debounce, mode/field FSM, inc
// strobe, blink. Ports: clk, rst (async high), bus (time_set_ctrl_if).
// Optional auto-repeat of inc: define AUTO_REPEAT_EN.
module time_set_ctrl #(
  parameter int DEB_MS          = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int BLINK_MS        = 250
) (
  input  logic           clk,
  input  logic           rst,
  time_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    M_RUN       = 2'd0,
    M_SET_TIME  = 2'd1,
    M_SET_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    F_HOUR = 2'd0,
    F_MIN  = 2'd1,
    F_SEC  = 2'd2
  } field_e;

  localparam int DW = $clog2(DEB_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [DW-1:0] DEB_END = DW'(DEB_MS - 1);
  localparam logic [BW-1:0] BL_END  = BW'(BLINK_MS - 1);

  // key index: 0 mode, 1 sel, 2 inc
  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    db_q, dbp_q;
  logic [DW-1:0] dcnt_q [3];

  assign raw = {bus.key_inc, bus.key_sel, bus.key_mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      dbp_q <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      dbp_q <= db_q;
      for (int i = 0; i < 3; i++) begin
        if (s2_q[i] == db_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (bus.tick_1k) begin
          if (dcnt_q[i] == DEB_END) begin
            db_q[i]   <= s2_q[i];
            dcnt_q[i] <= '0;
          end else begin
            dcnt_q[i] <= dcnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  logic [2:0] press;
  logic       ev_mode, ev_sel, ev_inc;

  // lower-priority events are dropped when a higher one coincides
  assign press   = db_q & ~dbp_q;
  assign ev_mode = press[0];
  assign ev_sel  = press[1] & ~press[0];
  assign ev_inc  = press[2] & ~press[1] & ~press[0];

  mode_e         mode_q, mode_d;
  field_e        field_q, field_d;
  logic          set_q;
  logic          time_en_q, alarm_en_q, run_en_q;
  logic [2:0]    adj_q;
  logic          inc_q, inc_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  assign set_q = (mode_q != M_RUN);

  always_comb begin
    mode_d  = mode_q;
    field_d = field_q;
    if (ev_mode) begin
      unique case (mode_q)
        M_RUN:      mode_d = M_SET_TIME;
        M_SET_TIME: mode_d = M_SET_ALARM;
        default:    mode_d = M_RUN;
      endcase
      field_d = F_HOUR;
    end else if (ev_sel && set_q) begin
      unique case (field_q)
        F_HOUR:  field_d = F_MIN;
        F_MIN:   field_d = F_SEC;
        default: field_d = F_HOUR;
      endcase
    end
  end

  always_comb begin
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (mode_d == M_RUN) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (ev_mode) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (ev_sel) begin
      bcnt_d  = '0;
    end else if (bus.tick_1k) begin
      if (bcnt_q == BL_END) begin
        blink_d = ~blink_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                        REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_END  = RW'(REPEAT_DELAY_MS - 1);
  localparam logic [RW-1:0] RATE_END = RW'(REPEAT_RATE_MS - 1);

  logic          rep_on_q, rep_on_d;
  logic          rep_first_q, rep_first_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep_fire;

  // first interval uses the delay, later ones the rate
  always_comb begin
    rep_on_d    = rep_on_q;
    rep_first_d = rep_first_q;
    rcnt_d      = rcnt_q;
    rep_fire    = 1'b0;
    if (ev_inc && set_q) begin
      rep_on_d    = 1'b1;
      rep_first_d = 1'b1;
      rcnt_d      = '0;
    end else if (!rep_on_q || ev_mode || ev_sel ||
                 !db_q[2] || !set_q) begin
      rep_on_d = 1'b0;
      rcnt_d   = '0;
    end else if (bus.tick_1k) begin
      if (rcnt_q == (rep_first_q ? DLY_END : RATE_END)) begin
        rep_fire    = 1'b1;
        rep_first_d = 1'b0;
        rcnt_d      = '0;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_on_q    <= 1'b0;
      rep_first_q <= 1'b0;
      rcnt_q      <= '0;
    end else begin
      rep_on_q    <= rep_on_d;
      rep_first_q <= rep_first_d;
      rcnt_q      <= rcnt_d;
    end
  end

  assign inc_d = (ev_inc && set_q) || rep_fire;
`else
  if (REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_rep_cfg
  end

  assign inc_d = ev_inc && set_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= M_RUN;
      field_q    <= F_HOUR;
      time_en_q  <= 1'b0;
      alarm_en_q <= 1'b0;
      run_en_q   <= 1'b1;
      adj_q      <= 3'b000;
      inc_q      <= 1'b0;
      blink_q    <= 1'b1;
      bcnt_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      field_q    <= field_d;
      time_en_q  <= (mode_d == M_SET_TIME);
      alarm_en_q <= (mode_d == M_SET_ALARM);
      run_en_q   <= (mode_d != M_SET_TIME);
      adj_q      <= (mode_d == M_RUN) ? 3'b000 :
                    {field_d == F_HOUR,
                     field_d == F_MIN,
                     field_d == F_SEC};
      inc_q      <= inc_d;
      blink_q    <= blink_d;
      bcnt_q     <= bcnt_d;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.time_en   = time_en_q;
  assign bus.alarm_en  = alarm_en_q;
  assign bus.run_en    = run_en_q;
  assign bus.adjust_h  = adj_q[2];
  assign bus.adjust_m  = adj_q[1];
  assign bus.adjust_s  = adj_q[0];
  assign bus.inc_pulse = inc_q;
  assign bus.blink     = blink_q;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEB_MS, default 20: ticks a raw key must hold a new level before the debounced level changes.
REQ-002 Parameter REPEAT_DELAY_MS, default 500: ticks of continuous inc hold before auto-repeat starts.
REQ-003 Parameter REPEAT_RATE_MS, default 100: ticks between auto-repeat pulses.
REQ-004 Parameter BLINK_MS, default 250: ticks per blink half-period.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  system clock; all state on posedge clk.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 tick_1k  in  1  one-clk-wide 1 kHz enable; all ms timing counts these ticks.
REQ-009 key_mode, key_sel, key_inc  in  1 each  raw active-high buttons, asynchronous to clk.
REQ-010 mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM; value 3 is never driven.
REQ-011 time_en, alarm_en  out  1 each  adjust-path enables for the time and alarm registers.
REQ-012 adjust_h, adjust_m, adjust_s  out  1 each  one-hot selected field.
REQ-013 inc_pulse  out  1  one-clk strobe that increments the selected field.
REQ-014 run_en  out  1  timekeeping count enable.
REQ-015 blink  out  1  display blink for the selected field.

Function
REQ-016 Each key SHALL pass through a 2-flop synchronizer and then be debounced: a level counter advances only on tick_1k, and the debounced level flips after DEB_MS consecutive ticks at the new level; any mismatch clears the counter.
REQ-017 A press event SHALL be a one-clk pulse on a debounced 0->1 edge; a release generates no event.
REQ-018 The mode FSM SHALL step RUN->SET_TIME->SET_ALARM->RUN on each key_mode press.
REQ-019 On entry to SET_TIME or SET_ALARM, the field SHALL be HOUR.
REQ-020 A key_sel press in a set mode SHALL step the field HOUR->MIN->SEC->HOUR.
REQ-021 key_sel and key_inc presses in RUN SHALL be ignored.
REQ-022 adjust_h/m/s SHALL be one-hot per the field in set modes and all 0 in RUN.
REQ-023 time_en SHALL equal (mode==SET_TIME); alarm_en SHALL equal (mode==SET_ALARM); run_en SHALL equal (mode!=SET_TIME).
REQ-024 inc_pulse SHALL assert for exactly one clk, in the cycle after the clk in which the key_inc press event occurs, in a set mode only.
REQ-025 Simultaneous press events SHALL be prioritised mode > sel > inc; lower-priority events in that cycle are discarded.
REQ-026 blink SHALL be 1 in RUN, SHALL be set to 1 on entry to a set mode, and SHALL toggle every BLINK_MS ticks in a set mode; the blink counter restarts on each mode or field change.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On rst, in the same cycle and independent of clk, the block SHALL reach: mode=RUN, field=HOUR, time_en=alarm_en=0, adjust_*=0, inc_pulse=0, run_en=1, blink=1.
REQ-029 On rst, all debounce, repeat and blink counters SHALL clear and all debounced levels SHALL be 0.
REQ-030 A key held through reset release SHALL yield a press after DEB_MS ticks.
REQ-031 rst asserted mid-operation (for example during auto-repeat) SHALL abort it with no further inc_pulse.

Configuration
REQ-032 Macro AUTO_REPEAT_EN defined: while the debounced key_inc stays high in a set mode, a first repeat inc_pulse SHALL fire REPEAT_DELAY_MS ticks after the press event, then one every REPEAT_RATE_MS ticks.
REQ-033 With AUTO_REPEAT_EN defined, a mode change, a sel press or key_inc release SHALL stop auto-repeat; repeat resumes only after a fresh press.
REQ-034 Macro AUTO_REPEAT_EN undefined: one inc_pulse per press, and the repeat counters SHALL not be built.

Verification
REQ-035 Bench: reset, then key_mode held 25 ticks -> mode=1, time_en=1, run_en=0, adjust_h=1, blink=1.
REQ-036 Bench: in SET_TIME, key_inc with a 5-tick glitch, then a 25-tick press -> no pulse from the glitch, exactly one inc_pulse 20 ticks into the press.
REQ-037 Bench: in SET_ALARM, key_sel pressed 3 times -> adjust_m, then adjust_s, then adjust_h; alarm_en=1 throughout.
REQ-038 Bench: key_mode and key_inc debounced edges in the same clk while in SET_TIME -> mode=2, no inc_pulse, adjust_h=1.
REQ-039 Bench (AUTO_REPEAT_EN): key_inc held 1000 ticks in SET_TIME -> pulses at press, +500, +600, +700, +800, +900 ticks (6 total).
REQ-040 Bench: rst asserted during auto-repeat -> immediate reset state, no inc_pulse until a new press.
